fifo_burst_framer: RTL and testbench

Downstream drain stage for the synchronous FIFO. It pulls words over the FIFO's read port (`rd_en` / `dout` / `empty`, with registered `dout` one cycle after an accepted read) and presents them on a valid/ready stream. Words are grouped into fixed-length packets with `m_last` on the final beat. It sits between the FIFO and any stream consumer, such as a serializer or DMA.

---
 rtl/fifo_burst_framer_pkg.sv | 5 +
 rtl/fifo_burst_framer_if.sv | 19 +
 rtl/fifo_burst_framer_skid_buf.sv | 29 ++
 rtl/fifo_burst_framer.sv | 76 +++++++
 tb/tb_fifo_burst_framer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_framer_pkg.sv
// fifo_stream_pkg: shared types for the FIFO burst framer.
//   framer_state_t - framer FSM states (CSUM is only reached when FRAME_CSUM_EN is defined)
package fifo_stream_pkg;
   typedef enum logic [1:0] {IDLE, DATA, CSUM} framer_state_t;
endpackage

// File: rtl/fifo_burst_framer_if.sv
// fifo_burst_framer_if: FIFO read port plus valid/ready output stream of the framer.
//   fifo_rd_en/fifo_dout/fifo_empty - FIFO read side
//   m_valid/m_ready/m_data/m_last   - output stream
//   pkt_done                        - pulse after a packet completes
//   master: framer side, slave: environment side
interface fifo_burst_framer_if #(parameter int WIDTH = 16);
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_empty;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic             pkt_done;
   modport master (output fifo_rd_en, m_valid, m_data, m_last, pkt_done,
                   input  fifo_dout, fifo_empty, m_ready);
   modport slave  (input  fifo_rd_en, m_valid, m_data, m_last, pkt_done,
                   output fifo_dout, fifo_empty, m_ready);
endinterface

// File: rtl/fifo_burst_framer_skid_buf.sv
// stream_skid_buf: 2-entry in-order buffer between FIFO read data and the stream.
//   clk, rst_n (async, active-low); push/push_data write the tail;
//   pop removes the head; head_data is the head word; occ is occupancy 0..2
module stream_skid_buf #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       occ
);
   logic [WIDTH-1:0] d1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_data <= '0;
         d1        <= '0;
         occ       <= '0;
      end else begin
         occ <= occ + 2'(push) - 2'(pop);
         // on pop the head takes the second entry if present, else the incoming word
         if (pop) head_data <= (occ == 2'd2) ? d1 : push_data;
         else if (push && occ == 2'd0) head_data <= push_data;
         if (push && (occ == 2'd2 || (occ == 2'd1 && !pop))) d1 <= push_data;
      end
   end
endmodule

// File: rtl/fifo_burst_framer.sv
// fifo_burst_framer: drains a synchronous FIFO into fixed-length valid/ready packets.
//   clk, rst_n (async, active-low); bus (fifo_burst_framer_if.master) carries the
//   FIFO read port, the output stream and pkt_done.
//   Optional macro FRAME_CSUM_EN appends an XOR checksum beat to every packet.
module fifo_burst_framer
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int BURST_LEN = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   fifo_burst_framer_if.master bus
);
   localparam int CNT_W = $clog2(BURST_LEN + 1);
   framer_state_t    state, state_nx;
   logic [CNT_W-1:0] beat;
   logic [WIDTH-1:0] head;
   logic [1:0]       occ, occ_nx;
   logic             rd_q, pop, last, in_csum, csum_ack, done_nx;
   stream_skid_buf #(.WIDTH(WIDTH)) u_buf (
      .clk,
      .rst_n,
      .push      (rd_q),
      .push_data (bus.fifo_dout),
      .pop,
      .head_data (head),
      .occ
   );
   assign pop      = (occ != 2'd0) && bus.m_ready && !in_csum;
   assign last     = beat == CNT_W'(BURST_LEN - 1);
   assign csum_ack = in_csum && bus.m_ready;
   // occupancy after this edge, counting the word already in flight
   assign occ_nx         = occ + 2'(rd_q) - 2'(pop);
   assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && occ_nx <= 2'd1;
   assign bus.m_valid    = in_csum || occ != 2'd0;
`ifdef FRAME_CSUM_EN
   logic [WIDTH-1:0] acc;
   assign in_csum    = state == CSUM;
   assign bus.m_data = in_csum ? acc : head;
   assign bus.m_last = in_csum;
   assign done_nx    = csum_ack;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else if (pop) acc <= (beat == '0 ? '0 : acc) ^ head;
   end
`else
   assign in_csum    = 1'b0;
   assign bus.m_data = head;
   assign bus.m_last = (occ != 2'd0) && last;
   assign done_nx    = pop && last;
`endif
   always_comb begin
      state_nx = state;
      if (state == IDLE && occ != 2'd0) state_nx = DATA;
`ifdef FRAME_CSUM_EN
      if (pop && last) state_nx = CSUM;
      if (csum_ack) state_nx = (occ_nx == 2'd0) ? IDLE : DATA;
`else
      if (pop && last) state_nx = (occ_nx == 2'd0) ? IDLE : DATA;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         beat         <= '0;
         rd_q         <= 1'b0;
         bus.pkt_done <= 1'b0;
      end else begin
         state        <= state_nx;
         rd_q         <= bus.fifo_rd_en;
         bus.pkt_done <= done_nx;
         if (pop) beat <= last ? '0 : beat + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_burst_framer.sv
// tb_fifo_burst_framer: self-checking bench for fifo_burst_framer (also builds with FRAME_CSUM_EN).
//   Behavioural FIFO feeding the DUT, queue-based expected-beat model, a cycle table
//   for the first packet, directed corner sequences and a randomized phase.
module tb_fifo_burst_framer;
   localparam int BL = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_burst_framer_if #(.WIDTH(16)) bus ();
   fifo_burst_framer_if #(.WIDTH(16)) bus1 ();
   fifo_burst_framer #(.WIDTH(16), .BURST_LEN(BL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   fifo_burst_framer #(.WIDTH(16), .BURST_LEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int n_cmp = 0, n_err = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural FIFO, cleared by the shared reset
   logic [15:0] mem [1024];
   int wr_ptr = 0, rd_ptr = 0;
   assign bus.fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= wr_ptr;
         bus.fifo_dout <= '0;
      end else if (bus.fifo_rd_en) begin
         bus.fifo_dout <= mem[rd_ptr % 1024];
         rd_ptr <= rd_ptr + 1;
      end
   end

   // BURST_LEN=1 instance: endless counting source, always ready
   assign bus1.fifo_empty = 1'b0;
   assign bus1.m_ready = 1'b1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus1.fifo_dout <= '0;
      else if (bus1.fifo_rd_en) bus1.fifo_dout <= bus1.fifo_dout + 16'd1;
   end

   // expected stream: every pushed word in order, packets of BL words
   typedef struct packed {logic [15:0] d; logic l; logic c;} beat_t;
   beat_t exp_q[$];
   int pos = 0;
   logic [15:0] acc = '0;
   task automatic push(input logic [15:0] w);
      mem[wr_ptr % 1024] = w;
      wr_ptr++;
`ifdef FRAME_CSUM_EN
      acc = (pos == 0 ? 16'h0 : acc) ^ w;
      exp_q.push_back('{w, 1'b0, 1'b0});
      if (pos == BL - 1) exp_q.push_back('{acc, 1'b1, 1'b1});
`else
      exp_q.push_back('{w, pos == BL - 1, 1'b0});
`endif
      pos = (pos + 1) % BL;
   endtask
   task automatic reset_model();
      exp_q.delete();
      pos = 0;
      acc = '0;
   endtask

   // monitor: samples 3 time units after each falling edge
   logic exp_done = 0, exp_done1 = 0, hold = 0;
   logic [15:0] hold_d = '0, last_d = '0;
   int outs = 0, n_last = 0, n_done = 0;
   beat_t e;
   always begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
         exp_done = 0;
         exp_done1 = 0;
         hold = 0;
         outs = 0;
      end else begin
         chk("pkt_done", bus.pkt_done, exp_done);
         if (bus.pkt_done) n_done++;
         if (hold) begin
            chk("held valid", bus.m_valid, 1);
            chk("held data", bus.m_data, hold_d);
         end
         if (bus.fifo_empty) chk("rd_en on empty", bus.fifo_rd_en, 0);
         exp_done = 0;
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected beat: got %0h expected none", bus.m_data);
            end else begin
               e = exp_q.pop_front();
               chk("beat data", bus.m_data, e.d);
               chk("beat last", bus.m_last, e.l);
               exp_done = e.l;
               if (!e.c) outs--;
               if (bus.m_last) begin
                  n_last++;
                  last_d = bus.m_data;
               end
            end
         end
         outs += int'(bus.fifo_rd_en);
         chk("words in flight <= 2", outs <= 2, 1);
         hold = bus.m_valid && !bus.m_ready;
         hold_d = bus.m_data;
`ifndef FRAME_CSUM_EN
         chk("len1 pkt_done", bus1.pkt_done, exp_done1);
         if (bus1.m_valid) chk("len1 last", bus1.m_last, 1);
         exp_done1 = bus1.m_valid;
`endif
      end
   end

   task automatic drain();
      bus.m_ready = 1;
      for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.m_valid); i++) @(negedge clk);
      chk("drain left", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   typedef struct {logic rdy, rd, vld; logic [15:0] dat; logic lst, dn;} vec_t;
   vec_t tbl[9];
   int cnt, d0, l0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1, 1, 0, 16'h0, 0, 0};
      tbl[1] = '{1, 1, 0, 16'h0, 0, 0};
      tbl[2] = '{1, 1, 1, 16'h1, 0, 0};
      tbl[3] = '{1, 1, 1, 16'h2, 0, 0};
      tbl[4] = '{1, 0, 1, 16'h3, 0, 0};
`ifdef FRAME_CSUM_EN
      tbl[5] = '{1, 0, 1, 16'h4, 0, 0};
      tbl[6] = '{1, 0, 1, 16'h4, 1, 0};
      tbl[7] = '{1, 0, 0, 16'h0, 0, 1};
`else
      tbl[5] = '{1, 0, 1, 16'h4, 1, 0};
      tbl[6] = '{1, 0, 0, 16'h0, 0, 1};
      tbl[7] = '{1, 0, 0, 16'h0, 0, 0};
`endif
      tbl[8] = '{1, 0, 0, 16'h0, 0, 0};
      bus.m_ready = 0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      #3;
      chk("reset m_valid", bus.m_valid, 0);
      chk("reset m_data", bus.m_data, 0);
      chk("reset m_last", bus.m_last, 0);
      chk("reset pkt_done", bus.pkt_done, 0);
      chk("reset rd_en", bus.fifo_rd_en, 0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 1; i <= 4; i++) push(16'(i));
      for (int i = 0; i < 9; i++) begin
         bus.m_ready = tbl[i].rdy;
         #3;
         chk($sformatf("c%0d rd_en", i), bus.fifo_rd_en, tbl[i].rd);
         chk($sformatf("c%0d m_valid", i), bus.m_valid, tbl[i].vld);
         chk($sformatf("c%0d m_last", i), bus.m_last, tbl[i].lst);
         chk($sformatf("c%0d pkt_done", i), bus.pkt_done, tbl[i].dn);
         if (tbl[i].vld) chk($sformatf("c%0d m_data", i), bus.m_data, tbl[i].dat);
         @(negedge clk);
      end
      drain();

      // two back-to-back packets without bubbles
      for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i));
      for (int i = 0; i < 10 && !bus.m_valid; i++) @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         #3;
         cnt += int'(bus.m_valid);
         @(negedge clk);
      end
      chk("consecutive valid", cnt, 8);
      drain();

      // backpressure: only two reads while stalled, head held
      bus.m_ready = 0;
      for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i));
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         #3;
         cnt += int'(bus.fifo_rd_en);
         @(negedge clk);
      end
      chk("stalled reads", cnt, 2);
      chk("stalled head", bus.m_data, 16'h3000);
      drain();

      // FIFO runs dry mid-packet
      l0 = n_last;
      push(16'h4000);
      push(16'h4001);
      repeat (8) @(negedge clk);
      chk("dry m_valid", bus.m_valid, 0);
      chk("dry no last", n_last, l0);
      d0 = n_done;
      push(16'h4002);
      push(16'h4003);
      drain();
      chk("dry packet done", n_done, d0 + 1);
`ifdef FRAME_CSUM_EN
      chk("dry packet last beat", last_d, 16'h0000);
`else
      chk("dry packet last beat", last_d, 16'h4003);
`endif

      // checksum pattern
      push(16'h00F0);
      push(16'h0F00);
      push(16'h000F);
      push(16'hF000);
      drain();
`ifdef FRAME_CSUM_EN
      chk("pattern last beat", last_d, 16'hFFFF);
`else
      chk("pattern last beat", last_d, 16'hF000);
`endif

      // randomized traffic and backpressure
      for (int i = 0; i < 400; i++) begin
         bus.m_ready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 2) == 0) push(16'($urandom));
         @(negedge clk);
      end
      while (pos != 0) push(16'($urandom));
      drain();

      // asynchronous reset with a full buffer
      bus.m_ready = 0;
      for (int i = 0; i < 6; i++) push(16'h6000 + 16'(i));
      repeat (6) @(negedge clk);
      #2;
      rst_n = 0;
      reset_model();
      #1;
      chk("async m_valid", bus.m_valid, 0);
      chk("async m_data", bus.m_data, 0);
      chk("async m_last", bus.m_last, 0);
      chk("async pkt_done", bus.pkt_done, 0);
      push(16'h6ABC);
      #1;
      chk("rd_en held in reset", bus.fifo_rd_en, 0);
      @(negedge clk);
      reset_model();
      @(negedge clk);
      rst_n = 1;
      d0 = n_done;
      for (int i = 0; i < 4; i++) push(16'h7000 + 16'(i));
      drain();
      chk("post-reset packet done", n_done, d0 + 1);
`ifndef FRAME_CSUM_EN
      chk("post-reset last beat", last_d, 16'h7003);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
